// File: rtl/sysid_regs_v2.sv
// rtl/sysid_regs_v2.sv - Avalon-MM system-ID register bank with scratch, control and uptime counter
module sysid_regs_v2 #(
  parameter logic [31:0] SYSTEM_ID       = 32'h524B_9A15,
  parameter logic [31:0] BUILD_TIMESTAMP = 32'h0,
  parameter int          UPTIME_W        = 64,
  parameter logic [31:0] SCRATCH_INIT    = 32'h0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  localparam logic [2:0] ADDR_ID      = 3'd0;
  localparam logic [2:0] ADDR_TSTAMP  = 3'd1;
  localparam logic [2:0] ADDR_VERSION = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH = 3'd3;
  localparam logic [2:0] ADDR_UP_LO   = 3'd4;
  localparam logic [2:0] ADDR_UP_HI   = 3'd5;
  localparam logic [2:0] ADDR_CTRL    = 3'd6;

  localparam logic [31:0] VERSION = {16'h0002, 16'(UPTIME_W)};

  logic [UPTIME_W-1:0] uptime;
  logic [31:0]         scratch;
  logic [31:0]         hi_shadow;
  logic                freeze;

  logic                wr_en;
  logic                ctrl_wr;
  logic                clear;
  logic [31:0]         uptime_hi_ext;
  logic [31:0]         rd_mux;

  // A read presented together with a write wins; the write is dropped.
  assign wr_en         = write & ~read;
  assign ctrl_wr       = wr_en && (address == ADDR_CTRL) && byteenable[0];
  assign clear         = ctrl_wr & writedata[0];
  assign uptime_hi_ext = 32'(uptime[UPTIME_W-1:32]);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= '0;
    end else if (clear) begin
      uptime <= '0;
    end else if (!freeze) begin
      uptime <= uptime + {{(UPTIME_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      freeze <= 1'b0;
    end else if (ctrl_wr) begin
      freeze <= writedata[1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= SCRATCH_INIT;
    end else if (wr_en && (address == ADDR_SCRATCH)) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch[8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (address)
      ADDR_ID:      rd_mux = SYSTEM_ID;
      ADDR_TSTAMP:  rd_mux = BUILD_TIMESTAMP;
      ADDR_VERSION: rd_mux = VERSION;
      ADDR_SCRATCH: rd_mux = scratch;
      ADDR_UP_LO:   rd_mux = uptime[31:0];
      ADDR_UP_HI:   rd_mux = hi_shadow;
      ADDR_CTRL:    rd_mux = {30'h0, freeze, 1'b0};
      default:      rd_mux = 32'h0;
    endcase
  end

  // hi_shadow samples the same pre-increment value as the LO read for a coherent pair.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= 32'h0;
      readdatavalid <= 1'b0;
      hi_shadow     <= 32'h0;
    end else begin
      readdatavalid <= read;
      if (read) begin
        readdata <= rd_mux;
        if (address == ADDR_UP_LO) begin
          hi_shadow <= uptime_hi_ext;
        end
      end
    end
  end

endmodule

// File: doc/sysid_regs_v2.md
Name: sysid_regs_v2

Overview:
- Parametrised successor to the fixed system-ID peripheral: an Avalon-MM slave exposing a bank of read-only identification registers.
- Adds a read/write scratch register with byte enables and a free-running uptime counter that reads atomically through a hi-word snapshot.
- Adds a control register to clear or freeze the counter.
- Sits on the processor data master's interconnect; software uses it to verify it runs on the intended hardware build and to measure elapsed cycles.

Parameters:
- SYSTEM_ID, 32'h524B_9A15, value returned at register 0.
- BUILD_TIMESTAMP, 32'h0, build time in seconds since epoch, returned at register 1.
- UPTIME_W, 64, uptime counter width; legal range 33..64.
- SCRATCH_INIT, 32'h0, reset value of the scratch register.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  word address of the register.
- read  input  1  read strobe, one cycle per transfer.
- write  input  1  write strobe, one cycle per transfer.
- writedata  input  32  write data.
- byteenable  input  4  byte lanes for writes.
- readdata  output  32  registered read data.
- readdatavalid  output  1  high for exactly one cycle, one cycle after an accepted read.

Behaviour:
- Interface timing:
  - Interface is always ready (no waitrequest); fixed read latency 1.
  - Read accepted in cycle N gives readdatavalid=1 and readdata valid in cycle N+1.
  - readdata holds its last value until the next read.
  - Writes complete in the cycle they are presented.
- Reset (async assert, sync deassert handled upstream):
  - readdata=0, readdatavalid=0.
  - scratch=SCRATCH_INIT, uptime=0, hi_shadow=0, ctrl=0.
- Register map (word addresses):
  - 0 ID: RO, SYSTEM_ID.
  - 1 TIMESTAMP: RO, BUILD_TIMESTAMP.
  - 2 VERSION: RO, {16'h0002, 16'(UPTIME_W)}.
  - 3 SCRATCH: RW. Byte lane i is written from writedata[8i+7:8i] when byteenable[i]=1.
  - 4 UPTIME_LO: RO, uptime[31:0]. The same read loads hi_shadow with uptime[UPTIME_W-1:32], zero-extended to 32 bits.
  - 5 UPTIME_HI: RO, returns hi_shadow. Does not change hi_shadow.
  - 6 CTRL: bit0 CLEAR, write-1 self-clearing, reads as 0. bit1 FREEZE, RW. Bits 31:2 read as 0 and ignore writes.
  - 7: reads as 0, writes ignored.
- Writes to RO addresses are ignored. Byteenable affects only SCRATCH and CTRL byte 0.
- Uptime counter:
  - Increments by 1 each cycle when FREEZE=0 and no CLEAR is being applied.
  - Wraps from all-ones to 0 with no flag.
  - A write of CTRL with bit0=1 sets the counter to 0 at the end of that cycle; counting resumes the next cycle unless FREEZE=1.
  - CLEAR has priority over increment.
  - A CTRL write with bits 1:0 = 2'b11 clears and freezes at 0.
- Sampling rules:
  - A UPTIME_LO read returns the counter value present in the read cycle, i.e. before that cycle's increment or clear.
  - hi_shadow is captured from that same value, so the LO/HI pair is coherent.
- Simultaneous events:
  - read and write in the same cycle (illegal on the bus): the read is performed and the write is dropped.
  - CLEAR write while the counter is at wrap: the clear wins.
- Reset mid-operation: a pending readdatavalid is killed; no response is issued for a read accepted in the cycle reset asserts.

Test Plan:
- Release reset, read addr 0, 1, 2 back-to-back -> readdatavalid one cycle after each read; data 32'h524B9A15, BUILD_TIMESTAMP, 32'h00020040 (UPTIME_W=64).
- Write SCRATCH 32'hDEADBEEF with byteenable=4'b1111, then 32'h00001234 with byteenable=4'b0011, then read -> 32'hDEAD1234; after reset, read -> SCRATCH_INIT.
- Force uptime to 64'h0000_0001_FFFF_FFFF (CLEAR, then count, or via hierarchical force), read LO then HI several cycles later -> LO=32'hFFFFFFFF, HI=32'h00000001; HI does not reflect the later carry.
- Write CTRL=2'b10 (freeze), read LO twice 10 cycles apart -> equal values; write CTRL=2'b01 -> next LO read small (≤3), CTRL reads 0.
- Assert read and write to SCRATCH in the same cycle -> SCRATCH unchanged, readdatavalid=1 next cycle with old value.
- Assert reset_n=0 in the cycle after a read -> readdatavalid=0 immediately, all outputs 0 until reset releases.
